// File: rtl/morse_pkg.sv
// Shared state encoding and Morse unit constants for the LED sequencer.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MARK     = 3'd1,
    SYM_GAP  = 3'd2,
    CHAR_GAP = 3'd3,
    WORD_GAP = 3'd4
  } state_t;

  localparam logic [2:0] DOT_UNITS      = 3'd1;
  localparam logic [2:0] DASH_UNITS     = 3'd3;
  localparam logic [2:0] SYM_GAP_UNITS  = 3'd1;
  localparam logic [2:0] CHAR_GAP_UNITS = 3'd3;
  localparam logic [2:0] WORD_GAP_UNITS = 3'd7;

  // Mark length in units for one symbol bit (1 = dash).
  function automatic logic [2:0] mark_units(input logic dash);
    return dash ? DASH_UNITS : DOT_UNITS;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Free-running Morse unit timer; unit_tick marks the last cycle of each unit.
module morse_unit_timer #(
  parameter int unsigned UNIT_CYCLES = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic unit_tick
);

  localparam int unsigned CNT_W = $clog2(UNIT_CYCLES);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(UNIT_CYCLES - 2);

  logic [CNT_W-1:0] count;

  // unit_tick is registered one count early so it lines up with count == LAST.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count     <= '0;
      unit_tick <= 1'b0;
    end else begin
      count     <= (count == LAST) ? '0 : count + CNT_W'(1);
      unit_tick <= (count == LAST_M1);
    end
  end

endmodule

// File: rtl/morse_sequencer.sv
// Transmits one Morse character (or word space) per accepted request on the LED.
module morse_sequencer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 50000000,
  parameter int unsigned MAX_SYMS    = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MAX_SYMS-1:0] sym_bits,
  input  logic [2:0]          sym_len,
  output logic                LED,
  output logic                busy,
  output logic                done
);

  state_t              state, state_nx;
  logic [2:0]          units, units_nx;
  logic [2:0]          idx, idx_nx;
  logic [2:0]          len, len_nx;
  logic [MAX_SYMS-1:0] bits, bits_nx;
  logic                done_nx;
  logic                unit_tick;
  logic                clear_c;
  logic                last_unit_c;

  // Every state change restarts the unit timer so durations are exact multiples.
  assign clear_c     = (state_nx != state);
  assign last_unit_c = unit_tick && (units == 3'd1);

  morse_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear_c),
    .unit_tick(unit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      units    <= 3'd0;
      idx      <= 3'd0;
      len      <= 3'd0;
      bits     <= '0;
      LED      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nx;
      units    <= units_nx;
      idx      <= idx_nx;
      len      <= len_nx;
      bits     <= bits_nx;
      LED      <= (state_nx == MARK);
      busy     <= (state_nx != IDLE);
      done     <= done_nx;
      in_ready <= (state_nx == IDLE);
    end
  end

  always_comb begin
    state_nx = state;
    units_nx = units;
    idx_nx   = idx;
    len_nx   = len;
    bits_nx  = bits;
    done_nx  = 1'b0;

    if (unit_tick && (units != 3'd1) && (state != IDLE)) begin
      units_nx = units - 3'd1;
    end

    unique case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          bits_nx = sym_bits;
          idx_nx  = 3'd0;
          len_nx  = (32'(sym_len) > MAX_SYMS) ? 3'(MAX_SYMS) : sym_len;
          if (sym_len == 3'd0) begin
            state_nx = WORD_GAP;
            units_nx = WORD_GAP_UNITS;
          end else begin
            state_nx = MARK;
            units_nx = mark_units(sym_bits[0]);
          end
        end
      end
      MARK: begin
        if (last_unit_c) begin
          if ((idx + 3'd1) < len) begin
            state_nx = SYM_GAP;
            units_nx = SYM_GAP_UNITS;
          end else begin
            state_nx = CHAR_GAP;
            units_nx = CHAR_GAP_UNITS;
          end
        end
      end
      SYM_GAP: begin
        // Current symbol always sits in bits[0]; shift to expose the next one.
        if (last_unit_c) begin
          state_nx = MARK;
          idx_nx   = idx + 3'd1;
          bits_nx  = bits >> 1;
          units_nx = mark_units(bits[1]);
        end
      end
      CHAR_GAP, WORD_GAP: begin
        if (last_unit_c) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule
